dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Memory-stage data-memory controller between the processor's MEM-stage outputs (memRead/memWrite/func3/aluOut/rs2Data) and a word-wide synchronous single-port data RAM that has no byte enables.
- Performs sign/zero-extended sub-word loads and read-modify-write sub-word stores, and drives the mem_ready handshake that the hazard unit uses to freeze the pipeline.

Parameters:
- DATA_WIDTH, 32, data and address width in bits.
- FUNC3_WIDTH, 3, width of the load/store size code.
- DM_MEM_DEPTH, 4096, RAM depth in 32-bit words; must be a power of 2. ADDR_W = $clog2(DM_MEM_DEPTH).

Ports:
- clk  input  1  clock; everything is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- memRead  input  1  load request from the MEM stage.
- memWrite  input  1  store request from the MEM stage.
- func3  input  FUNC3_WIDTH  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  DATA_WIDTH  byte address (aluOut).
- wdata  input  DATA_WIDTH  store data (rs2Data).
- rdata  output  DATA_WIDTH  extended load result, registered.
- ready  output  1  request complete / unit idle.
- ramAddr  output  ADDR_W  RAM word index.
- ramRe  output  1  RAM read strobe.
- ramWe  output  1  RAM write strobe.
- ramWdata  output  DATA_WIDTH  RAM write word.
- ramRdata  input  DATA_WIDTH  RAM read word, valid one cycle after ramRe.

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, rdata 0, ramRe 0, ramWe 0, ramAddr 0, ramWdata 0.
- A reset during a request aborts it. ramWe drops immediately and no partial write completes.
- Request capture: req = memRead | memWrite. In IDLE with req, the unit latches addr, func3, wdata and the operation type. Write wins if both are high.
- Requests must stay stable until ready=1.
- ready (combinational):
  - 1 in IDLE when req=0.
  - 0 in IDLE when req=1.
  - 0 in RD_REQ, RD_WAIT and WR.
  - 1 in DONE.
- The request is consumed in DONE. DONE always goes to IDLE, and a new req seen in IDLE starts the next access, so back-to-back requests are legal.
- State transitions:
  - IDLE → WR for a full-word store.
  - IDLE → RD_REQ for any load or sub-word store.
  - RD_REQ: ramRe=1, ramAddr=addr[ADDR_W+1:2] → RD_WAIT.
  - RD_WAIT, load: rdata <= extract(ramRdata) → DONE.
  - RD_WAIT, sub-word store: merge register <= ramRdata with the selected lane(s) replaced by wdata[7:0] or wdata[15:0] → WR.
  - WR: ramWe=1, ramWdata = merged word (or wdata for SW) → DONE.
- Latency from the request being seen in IDLE (cycle 0) to ready=1:
  - load: cycle 3.
  - SW: cycle 2.
  - SB/SH: cycle 4.
- Extraction:
  - Byte lane = addr[1:0]. Half lane = addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- Address wrap: word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so access wraps modulo DM_MEM_DEPTH.
- Reserved func3 codes (011, 110, 111) are treated as W.
- rdata holds its last load value across stores and idle cycles.
- Misalignment (H at addr[0]=1, W at addr[1:0]≠0) is handled per the optional feature.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit, reset 0).
  - A misaligned request goes IDLE → DONE with no RAM access.
  - misaligned=1 during DONE only. rdata is unchanged and memory is unchanged.
- Undefined:
  - No port is added.
  - Low address bits are force-aligned: H ignores addr[0]; W ignores addr[1:0].

Decomposition:
- The shared definitions package gains:
  - mem_size_t enum: MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_BU=3'b100, MEM_HU=3'b101.
  - dmem_state_t enum: IDLE, RD_REQ, RD_WAIT, WR, DONE.
- One combinational sub-module, load_store_align, holds lane extraction with sign/zero-extension and store-lane merge. The FSM and registers stay in dmem_access_unit.

Test Plan:
- Full-word round trip: SW addr=0x10, wdata=0xDEADBEEF → ramWe at cycle 1, word index 4, ready at cycle 2. Then LW 0x10 → ready at cycle 3, rdata=0xDEADBEEF.
- Byte extension: RAM word 4 = 0x80FF7F01. LB 0x13 → 0xFFFFFF80. LBU 0x13 → 0x00000080. LB 0x11 → 0x0000007F. LH 0x12 → 0xFFFF80FF. LHU 0x12 → 0x000080FF.
- Sub-word store RMW: word 4 = 0x11223344. SB 0x11 with wdata=0xAA → RAM 0x1122AA44, ready at cycle 4. Then SH 0x12 with wdata=0xBEEF → 0xBEEFAA44.
- Back-to-back and idle: LW then SW issued on consecutive requests → ready is high one cycle each, no request is dropped; ready=1 whenever idle with no request. With memRead=memWrite=1 → only the write occurs.
- Wrap and reset: SW to addr = 4*DM_MEM_DEPTH+8 → ramAddr=2. Assert rst during WR of an SB → ramWe falls immediately, state IDLE, rdata=0, word unchanged.
- Misalignment: LW 0x12 with DMEM_MISALIGN_TRAP_EN defined → ready at cycle 1, misaligned=1, no ramRe/ramWe. Without the macro → reads word index 4.

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the data-memory access unit: access-size codes, FSM states
// and the func3 decode / alignment helpers.
package dmem_access_unit_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR,
        DONE
    } dmem_state_t;

    // Reserved size codes behave as full-word accesses.
    function automatic mem_size_t decodeSize(input logic [2:0] f3);
        case (f3)
            3'b000:  return MEM_B;
            3'b001:  return MEM_H;
            3'b100:  return MEM_BU;
            3'b101:  return MEM_HU;
            default: return MEM_W;
        endcase
    endfunction

    function automatic logic isMisaligned(input mem_size_t size, input logic [1:0] off);
        case (size)
            MEM_H, MEM_HU: return off[0];
            MEM_W:         return off != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_store_align.sv
// Lane steering for the data-memory unit: extended sub-word load extraction
// and sub-word store merge into a RAM word that has no byte enables.
module load_store_align
    import dmem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  mem_size_t             size,
    input  logic [1:0]            byteOff,
    input  logic [DATA_WIDTH-1:0] ramWord,
    input  logic [15:0]           storeData,
    output logic [DATA_WIDTH-1:0] loadData,
    output logic [DATA_WIDTH-1:0] mergedWord
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    // Half-word lane uses only byteOff[1], so odd halfword offsets fold down.
    always_comb begin
        selByte = ramWord[{byteOff, 3'b000} +: 8];
        selHalf = ramWord[{byteOff[1], 4'b0000} +: 16];

        loadData = ramWord;
        case (size)
            MEM_B:   loadData = {{(DATA_WIDTH-8){selByte[7]}}, selByte};
            MEM_BU:  loadData = {{(DATA_WIDTH-8){1'b0}}, selByte};
            MEM_H:   loadData = {{(DATA_WIDTH-16){selHalf[15]}}, selHalf};
            MEM_HU:  loadData = {{(DATA_WIDTH-16){1'b0}}, selHalf};
            default: loadData = ramWord;
        endcase

        mergedWord = ramWord;
        case (size)
            MEM_B, MEM_BU: mergedWord[{byteOff, 3'b000} +: 8]      = storeData[7:0];
            MEM_H, MEM_HU: mergedWord[{byteOff[1], 4'b0000} +: 16] = storeData;
            default:       mergedWord = ramWord;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory controller: sign/zero-extended loads, read-modify-write
// sub-word stores, ready handshake. DMEM_MISALIGN_TRAP_EN adds a misaligned trap.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNC3_WIDTH  = 3,
    parameter int DM_MEM_DEPTH = 4096,
    localparam int ADDR_W      = $clog2(DM_MEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   memRead,
    input  logic                   memWrite,
    input  logic [FUNC3_WIDTH-1:0] func3,
    input  logic [DATA_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic                   ready,
    output logic [ADDR_W-1:0]      ramAddr,
    output logic                   ramRe,
    output logic                   ramWe,
    output logic [DATA_WIDTH-1:0]  ramWdata,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic                   misaligned,
`endif
    input  logic [DATA_WIDTH-1:0]  ramRdata
);

    dmem_state_t             state, nextState;
    logic                    req;
    logic                    reqMis;
    mem_size_t               reqSize;
    mem_size_t               sizeQ;
    logic                    isWriteQ;
    logic [ADDR_W+1:0]       addrQ;
    logic [DATA_WIDTH-1:0]   wrWordQ;
    logic [DATA_WIDTH-1:0]   loadData;
    logic [DATA_WIDTH-1:0]   mergedWord;
    logic                    unusedAddr;

    assign req        = memRead | memWrite;
    assign reqSize    = decodeSize(func3[2:0]);
    // Upper address bits wrap the access modulo the RAM depth.
    assign unusedAddr = ^addr[DATA_WIDTH-1:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign reqMis = isMisaligned(reqSize, addr[1:0]);
`else
    assign reqMis = 1'b0;
`endif

    assign ramAddr  = addrQ[ADDR_W+1:2];
    assign ramWdata = wrWordQ;

    load_store_align #(.DATA_WIDTH(DATA_WIDTH)) uAlign (
        .size      (sizeQ),
        .byteOff   (addrQ[1:0]),
        .ramWord   (ramRdata),
        .storeData (wrWordQ[15:0]),
        .loadData  (loadData),
        .mergedWord(mergedWord)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        ready     = 1'b0;
        ramRe     = 1'b0;
        ramWe     = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    if (reqMis)
                        nextState = DONE;
                    else if (memWrite && reqSize == MEM_W)
                        nextState = WR;
                    else
                        nextState = RD_REQ;
                end
            end
            RD_REQ: begin
                ramRe     = 1'b1;
                nextState = RD_WAIT;
            end
            RD_WAIT: nextState = isWriteQ ? WR : DONE;
            WR: begin
                ramWe     = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // A full-word store writes wdata straight from capture; sub-word stores
    // overwrite it with the merged word while in RD_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrQ    <= '0;
            sizeQ    <= MEM_B;
            isWriteQ <= 1'b0;
            wrWordQ  <= '0;
            rdata    <= '0;
        end else begin
            if (state == IDLE && req) begin
                addrQ    <= addr[ADDR_W+1:0];
                sizeQ    <= reqSize;
                isWriteQ <= memWrite;
                wrWordQ  <= wdata;
            end
            if (state == RD_WAIT) begin
                if (isWriteQ)
                    wrWordQ <= mergedWord;
                else
                    rdata <= loadData;
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // High exactly for the DONE cycle that follows a trapped request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misaligned <= 1'b0;
        else
            misaligned <= (state == IDLE) && req && reqMis;
    end
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural synchronous RAM.
module tb_dmem_access_unit;

    localparam int DW    = 32;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          memRead = 1'b0;
    logic          memWrite = 1'b0;
    logic [2:0]    func3 = 3'b000;
    logic [DW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          ready;
    logic [AW-1:0] ramAddr;
    logic          ramRe;
    logic          ramWe;
    logic [DW-1:0] ramWdata;
    logic [DW-1:0] ramRdata;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic          misaligned;
`endif

    logic [DW-1:0] mem [0:DEPTH-1];

    int checks = 0;
    int failures = 0;

    int            lat, nRe, nWe, weCyc;
    logic [AW-1:0] ma;
    logic          mf;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ramWe) mem[ramAddr] <= ramWdata;
        if (ramRe) ramRdata <= mem[ramAddr];
    end

    dmem_access_unit #(.DATA_WIDTH(DW), .FUNC3_WIDTH(3), .DM_MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .func3(func3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .ramAddr(ramAddr),
        .ramRe(ramRe), .ramWe(ramWe), .ramWdata(ramWdata),
`ifdef DMEM_MISALIGN_TRAP_EN
        .misaligned(misaligned),
`endif
        .ramRdata(ramRdata)
    );

    // Drives one request starting at posedge+1 and returns at posedge+1 after
    // ready, leaving the inputs asserted so the caller may chain another.
    task automatic doReq(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [DW-1:0] a, input logic [DW-1:0] wd,
                         output int latO, output int reO, output int weO,
                         output int weCycO, output logic [AW-1:0] maO, output logic mfO);
        memRead = rd; memWrite = wr; func3 = f3; addr = a; wdata = wd;
        latO = -1; reO = 0; weO = 0; weCycO = -1; maO = '0; mfO = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (ramRe) begin reO++; maO = ramAddr; end
            if (ramWe) begin weO++; weCycO = c; maO = ramAddr; end
            if (ready) begin
                latO = c;
`ifdef DMEM_MISALIGN_TRAP_EN
                mfO = misaligned;
`endif
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic clearReq();
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        checks++; if ({ramRe, ramWe} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {ramRe, ramWe}); end
        checks++; if (ramAddr !== 12'd0 || ramWdata !== 32'h0) begin failures++; $display("FAIL rst_ram got=%h/%h exp=0/0", ramAddr, ramWdata); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_word_round_trip();
        doReq(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if (weCyc !== 1 || nWe !== 1 || nRe !== 0) begin failures++; $display("FAIL sw_strobes got=we@%0d nWe=%0d nRe=%0d exp=we@1 1 0", weCyc, nWe, nRe); end
        checks++; if (ma !== 12'd4) begin failures++; $display("FAIL sw_index got=%0d exp=4", ma); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", ready); end
        @(posedge clk); #1;
        doReq(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (lat !== 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", lat); end
        checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", rdata); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [6];
        logic [31:0] as  [6];
        logic [31:0] exp [6];
        f3s = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001};
        as  = '{32'h13, 32'h13, 32'h11, 32'h12, 32'h12, 32'h10};
        exp = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFF80FF, 32'h000080FF, 32'h00007F01};
        doReq(1'b0, 1'b1, 3'b010, 32'h10, 32'h80FF7F01, lat, nRe, nWe, weCyc, ma, mf);
        for (int i = 0; i < 6; i++) begin
            doReq(1'b1, 1'b0, f3s[i], as[i], 32'h0, lat, nRe, nWe, weCyc, ma, mf);
            checks++; if (rdata !== exp[i] || lat !== 3) begin failures++; $display("FAIL load_ext[%0d] got=%h lat=%0d exp=%h lat=3", i, rdata, lat, exp[i]); end
        end
        clearReq();
    endtask

    task automatic test_rmw();
        doReq(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, lat, nRe, nWe, weCyc, ma, mf);
        doReq(1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFFAA, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (lat !== 4 || nRe !== 1 || weCyc !== 3) begin failures++; $display("FAIL sb_timing got=lat%0d re%0d we@%0d exp=lat4 re1 we@3", lat, nRe, weCyc); end
        checks++; if (mem[4] !== 32'h1122AA44) begin failures++; $display("FAIL sb_mem got=%h exp=1122aa44", mem[4]); end
        checks++; if (rdata !== 32'h00007F01) begin failures++; $display("FAIL sb_rdata_hold got=%h exp=00007f01", rdata); end
        doReq(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000BEEF, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (lat !== 4 || mem[4] !== 32'hBEEFAA44) begin failures++; $display("FAIL sh_mem got=%h lat=%0d exp=beefaa44 lat=4", mem[4], lat); end
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
        doReq(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (lat !== 1 || mf !== 1'b1) begin failures++; $display("FAIL mis_lw got=lat%0d mis%b exp=lat1 mis1", lat, mf); end
        checks++; if (nRe !== 0 || nWe !== 0) begin failures++; $display("FAIL mis_noaccess got=re%0d we%0d exp=0 0", nRe, nWe); end
        checks++; if (rdata !== 32'h00007F01) begin failures++; $display("FAIL mis_rdata got=%h exp=00007f01", rdata); end
        doReq(1'b0, 1'b1, 3'b001, 32'h13, 32'h00001234, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (lat !== 1 || nWe !== 0 || mem[4] !== 32'hBEEFAA44) begin failures++; $display("FAIL mis_sh got=lat%0d we%0d mem=%h exp=lat1 we0 beefaa44", lat, nWe, mem[4]); end
        @(negedge clk);
        checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", misaligned); end
        @(posedge clk); #1;
`else
        doReq(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (lat !== 3 || ma !== 12'd4 || rdata !== 32'hBEEFAA44) begin failures++; $display("FAIL align_lw got=lat%0d idx%0d %h exp=lat3 idx4 beefaa44", lat, ma, rdata); end
        doReq(1'b1, 1'b0, 3'b001, 32'h13, 32'h0, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (rdata !== 32'hFFFFBEEF) begin failures++; $display("FAIL align_lh got=%h exp=ffffbeef", rdata); end
        doReq(1'b0, 1'b1, 3'b001, 32'h11, 32'h00005566, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (lat !== 4 || mem[4] !== 32'hBEEF5566) begin failures++; $display("FAIL align_sh got=%h lat=%0d exp=beef5566 lat=4", mem[4], lat); end
`endif
    endtask

    task automatic test_back_to_back();
        doReq(1'b0, 1'b1, 3'b010, 32'h20, 32'h0BADF00D, lat, nRe, nWe, weCyc, ma, mf);
        doReq(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, lat, nRe, nWe, weCyc, ma, mf);
        checks++; if (lat !== 3 || rdata !== 32'h0BADF00D) begin failures++; $display("FAIL b2b_lw got=%h lat=%0d exp=0badf00d lat=3", rdata, lat); end
        doReq(1'b0, 1'b1, 3'b010, 32'h24, 32'h12345678, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (lat !== 2 || mem[9] !== 32'h12345678) begin failures++; $display("FAIL b2b_sw got=%h lat=%0d exp=12345678 lat=2", mem[9], lat); end
        doReq(1'b1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (nRe !== 0 || nWe !== 1 || lat !== 2 || mem[8] !== 32'hCAFEF00D) begin failures++; $display("FAIL both_hi got=re%0d we%0d lat%0d %h exp=re0 we1 lat2 cafef00d", nRe, nWe, lat, mem[8]); end
        checks++; if (rdata !== 32'h0BADF00D) begin failures++; $display("FAIL store_rdata_hold got=%h exp=0badf00d", rdata); end
        doReq(1'b1, 1'b0, 3'b111, 32'h20, 32'h0, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (lat !== 3 || rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL reserved_f3 got=%h lat=%0d exp=cafef00d lat=3", rdata, lat); end
    endtask

    task automatic test_wrap();
        doReq(1'b0, 1'b1, 3'b010, 32'h4008, 32'h55AA55AA, lat, nRe, nWe, weCyc, ma, mf);
        clearReq();
        checks++; if (ma !== 12'd2 || mem[2] !== 32'h55AA55AA) begin failures++; $display("FAIL wrap got=idx%0d %h exp=idx2 55aa55aa", ma, mem[2]); end
    endtask

    task automatic test_reset_abort();
        doReq(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, lat, nRe, nWe, weCyc, ma, mf);
        memRead = 1'b0; memWrite = 1'b1; func3 = 3'b000; addr = 32'h10; wdata = 32'h000000EE;
        repeat (4) @(negedge clk);
        checks++; if (ramWe !== 1'b1) begin failures++; $display("FAIL abort_in_wr got=%b exp=1", ramWe); end
        #1 rst = 1'b1;
        #1;
        checks++; if (ramWe !== 1'b0 || ramRe !== 1'b0) begin failures++; $display("FAIL abort_we got=%b%b exp=00", ramWe, ramRe); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL abort_rdata got=%h exp=0", rdata); end
        clearReq();
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b exp=1", ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem[4] !== 32'h11223344) begin failures++; $display("FAIL abort_mem got=%h exp=11223344", mem[4]); end
    endtask

    initial begin
        test_reset();
        test_word_round_trip();
        test_load_ext();
        test_rmw();
        test_misalign();
        test_back_to_back();
        test_wrap();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
